svm_host_driver: RTL and testbench

- Host-side initiator for the SVM classifier's load and inference interfaces.
- Load: takes a start pulse, intercepts and a stream of weight rows, and drives the SVM's weight-load port: wait for write-ready, one intercept pulse, F_WIDTH active-low row writes, then a write-done pulse.
- Inference: accepts one paired sample (valence features + arousal features), issues the valence vector then the arousal vector on the feature handshake, collects the labels, and presents them on a result handshake.
- Sits between the sensor-fusion front end and the SVM top.

---
 rtl/svm_host_driver.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_svm_host_driver.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_host_driver.sv
// Host-side initiator: weight load sequencing and paired valence/arousal inference for the SVM core.
// Optional macro SVM_HOST_LATENCY_EN adds r_cycles (sample accept to result capture, saturating).
module svm_host_driver #(
  parameter int NBITS         = 9,
  parameter int VSUP_WIDTH    = 120,
  parameter int ASUP_WIDTH    = 155,
  parameter int F_WIDTH       = 214,
  parameter int LOG_SUP_WIDTH = 8,
  parameter int ICPT_W        = 2*NBITS+LOG_SUP_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic [ICPT_W-1:0]             cfg_v_intercept,
  input  logic [ICPT_W-1:0]             cfg_a_intercept,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [NBITS*VSUP_WIDTH-1:0]   w_v_support,
  input  logic [NBITS*ASUP_WIDTH-1:0]   w_a_support,
  input  logic [NBITS-1:0]              w_v_alpha,
  input  logic [NBITS-1:0]              w_a_alpha,
  input  logic                          mem_write_ready,
  output logic                          intercept_valid,
  output logic [ICPT_W-1:0]             v_in_intercept,
  output logic [ICPT_W-1:0]             a_in_intercept,
  output logic                          mem_we,
  output logic [7:0]                    mem_write_addr,
  output logic [NBITS*VSUP_WIDTH-1:0]   v_in_support,
  output logic [NBITS*ASUP_WIDTH-1:0]   a_in_support,
  output logic [NBITS-1:0]              v_in_alpha,
  output logic [NBITS-1:0]              a_in_alpha,
  output logic                          mem_write_done,
  output logic                          loaded,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [NBITS*F_WIDTH-1:0]      s_v_features,
  input  logic [NBITS*F_WIDTH-1:0]      s_a_features,
  output logic [NBITS*F_WIDTH-1:0]      in_features,
  output logic                          fin_valid,
  input  logic                          fin_ready,
  input  logic                          valence,
  input  logic                          arousal,
  input  logic                          dout_valid,
  output logic                          dout_ready,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic                          r_valence,
  output logic                          r_arousal
`ifdef SVM_HOST_LATENCY_EN
  ,
  output logic [15:0]                   r_cycles
`endif
);

  localparam int VW = NBITS*VSUP_WIDTH;
  localparam int AW = NBITS*ASUP_WIDTH;
  localparam int FW = NBITS*F_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_ICPT, S_WRITE, S_GAP, S_DONE,
    S_RUN, S_FEED_V, S_FEED_A, S_WAIT_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [8:0]          row_cnt_q, row_cnt_d;
  logic [ICPT_W-1:0]   v_icpt_q, v_icpt_d, a_icpt_q, a_icpt_d;
  logic                icpt_vld_q, icpt_vld_d;
  logic                mem_we_q, mem_we_d;
  logic [7:0]          addr_q, addr_d;
  logic [VW-1:0]       v_sup_q, v_sup_d;
  logic [AW-1:0]       a_sup_q, a_sup_d;
  logic [NBITS-1:0]    v_alpha_q, v_alpha_d, a_alpha_q, a_alpha_d;
  logic                done_q, done_d;
  logic                loaded_q, loaded_d;
  logic                w_rdy_q, w_rdy_d;
  logic                s_rdy_q, s_rdy_d;
  logic                dout_rdy_q, dout_rdy_d;
  logic                fin_vld_q, fin_vld_d;
  logic [FW-1:0]       feat_q, feat_d;
  logic [FW-1:0]       a_buf_q, a_buf_d;
  logic                r_vld_q, r_vld_d;
  logic                r_val_q, r_val_d, r_aro_q, r_aro_d;
`ifdef SVM_HOST_LATENCY_EN
  logic [15:0]         lat_q, lat_d;
  logic [15:0]         r_cyc_q, r_cyc_d;
  logic [15:0]         lat_inc;
`endif

  logic w_acc, s_acc, f_acc, d_acc;

  assign w_acc = w_valid & w_rdy_q;
  assign s_acc = s_valid & s_rdy_q;
  assign f_acc = fin_vld_q & fin_ready;
  assign d_acc = dout_valid & dout_rdy_q;
`ifdef SVM_HOST_LATENCY_EN
  assign lat_inc = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;
`endif

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    v_icpt_d   = v_icpt_q;
    a_icpt_d   = a_icpt_q;
    icpt_vld_d = 1'b0;
    mem_we_d   = 1'b1;
    addr_d     = addr_q;
    v_sup_d    = v_sup_q;
    a_sup_d    = a_sup_q;
    v_alpha_d  = v_alpha_q;
    a_alpha_d  = a_alpha_q;
    done_d     = 1'b0;
    loaded_d   = loaded_q;
    fin_vld_d  = fin_vld_q;
    feat_d     = feat_q;
    a_buf_d    = a_buf_q;
    r_vld_d    = r_vld_q;
    r_val_d    = r_val_q;
    r_aro_d    = r_aro_q;
`ifdef SVM_HOST_LATENCY_EN
    lat_d      = lat_q;
    r_cyc_d    = r_cyc_q;
`endif

    if (r_vld_q && r_ready) r_vld_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          v_icpt_d = cfg_v_intercept;
          a_icpt_d = cfg_a_intercept;
          state_d  = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (mem_write_ready) begin
          icpt_vld_d = 1'b1;
          loaded_d   = 1'b0;
          state_d    = S_ICPT;
        end
      end
      S_ICPT: begin
        row_cnt_d = '0;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        if (w_acc) begin
          mem_we_d  = 1'b0;
          addr_d    = row_cnt_q[7:0];
          v_sup_d   = w_v_support;
          a_sup_d   = w_a_support;
          v_alpha_d = w_v_alpha;
          a_alpha_d = w_a_alpha;
          row_cnt_d = row_cnt_q + 9'd1;
        end
        // The cycle after the final accept carries the last write; leave only then.
        if (row_cnt_q == 9'(F_WIDTH)) state_d = S_GAP;
      end
      S_GAP: begin
        done_d   = 1'b1;
        loaded_d = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (s_acc) begin
          feat_d    = s_v_features;
          a_buf_d   = s_a_features;
          fin_vld_d = 1'b1;
          state_d   = S_FEED_V;
`ifdef SVM_HOST_LATENCY_EN
          lat_d     = 16'd0;
`endif
        end else if (load_start) begin
          v_icpt_d = cfg_v_intercept;
          a_icpt_d = cfg_a_intercept;
          state_d  = S_WAIT_RDY;
        end
      end
      S_FEED_V: begin
`ifdef SVM_HOST_LATENCY_EN
        lat_d = lat_inc;
`endif
        if (f_acc) begin
          feat_d  = a_buf_q;
          state_d = S_FEED_A;
        end
      end
      S_FEED_A: begin
`ifdef SVM_HOST_LATENCY_EN
        lat_d = lat_inc;
`endif
        if (f_acc) begin
          fin_vld_d = 1'b0;
          state_d   = S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: begin
`ifdef SVM_HOST_LATENCY_EN
        lat_d = lat_inc;
`endif
        if (d_acc) begin
          r_val_d = valence;
          r_aro_d = arousal;
          r_vld_d = 1'b1;
          state_d = S_RUN;
`ifdef SVM_HOST_LATENCY_EN
          r_cyc_d = lat_inc;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Readies are registered: derived from the next-cycle state.
    w_rdy_d    = (state_d == S_WRITE) && (row_cnt_d != 9'(F_WIDTH));
    s_rdy_d    = (state_d == S_RUN) && loaded_d;
    dout_rdy_d = (state_d == S_WAIT_OUT) && !r_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      v_icpt_q   <= '0;
      a_icpt_q   <= '0;
      icpt_vld_q <= 1'b0;
      mem_we_q   <= 1'b1;
      addr_q     <= '0;
      v_sup_q    <= '0;
      a_sup_q    <= '0;
      v_alpha_q  <= '0;
      a_alpha_q  <= '0;
      done_q     <= 1'b0;
      loaded_q   <= 1'b0;
      w_rdy_q    <= 1'b0;
      s_rdy_q    <= 1'b0;
      dout_rdy_q <= 1'b0;
      fin_vld_q  <= 1'b0;
      feat_q     <= '0;
      a_buf_q    <= '0;
      r_vld_q    <= 1'b0;
      r_val_q    <= 1'b0;
      r_aro_q    <= 1'b0;
`ifdef SVM_HOST_LATENCY_EN
      lat_q      <= '0;
      r_cyc_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      v_icpt_q   <= v_icpt_d;
      a_icpt_q   <= a_icpt_d;
      icpt_vld_q <= icpt_vld_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      v_sup_q    <= v_sup_d;
      a_sup_q    <= a_sup_d;
      v_alpha_q  <= v_alpha_d;
      a_alpha_q  <= a_alpha_d;
      done_q     <= done_d;
      loaded_q   <= loaded_d;
      w_rdy_q    <= w_rdy_d;
      s_rdy_q    <= s_rdy_d;
      dout_rdy_q <= dout_rdy_d;
      fin_vld_q  <= fin_vld_d;
      feat_q     <= feat_d;
      a_buf_q    <= a_buf_d;
      r_vld_q    <= r_vld_d;
      r_val_q    <= r_val_d;
      r_aro_q    <= r_aro_d;
`ifdef SVM_HOST_LATENCY_EN
      lat_q      <= lat_d;
      r_cyc_q    <= r_cyc_d;
`endif
    end
  end

  assign w_ready         = w_rdy_q;
  assign intercept_valid = icpt_vld_q;
  assign v_in_intercept  = v_icpt_q;
  assign a_in_intercept  = a_icpt_q;
  assign mem_we          = mem_we_q;
  assign mem_write_addr  = addr_q;
  assign v_in_support    = v_sup_q;
  assign a_in_support    = a_sup_q;
  assign v_in_alpha      = v_alpha_q;
  assign a_in_alpha      = a_alpha_q;
  assign mem_write_done  = done_q;
  assign loaded          = loaded_q;
  assign s_ready         = s_rdy_q;
  assign in_features     = feat_q;
  assign fin_valid       = fin_vld_q;
  assign dout_ready      = dout_rdy_q;
  assign r_valid         = r_vld_q;
  assign r_valence       = r_val_q;
  assign r_arousal       = r_aro_q;
`ifdef SVM_HOST_LATENCY_EN
  assign r_cycles        = r_cyc_q;
`endif

endmodule

// File: tb/tb_svm_host_driver.sv
// Scoreboard bench for svm_host_driver: queued expectations for row writes, feature vectors and results.
module tb_svm_host_driver;
  localparam int NBITS = 9, VS = 120, AS = 155, FW = 214, LS = 8;
  localparam int IW = 2*NBITS+LS;
  localparam int VWD = NBITS*VS, AWD = NBITS*AS, FWD = NBITS*FW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, load_start, w_valid, w_ready, mem_write_ready, intercept_valid;
  logic [IW-1:0] cfg_v_intercept, cfg_a_intercept, v_in_intercept, a_in_intercept;
  logic [VWD-1:0] w_v_support, v_in_support;
  logic [AWD-1:0] w_a_support, a_in_support;
  logic [NBITS-1:0] w_v_alpha, w_a_alpha, v_in_alpha, a_in_alpha;
  logic mem_we, mem_write_done, loaded, s_valid, s_ready, fin_valid, fin_ready;
  logic [7:0] mem_write_addr;
  logic [FWD-1:0] s_v_features, s_a_features, in_features;
  logic valence, arousal, dout_valid, dout_ready, r_valid, r_ready, r_valence, r_arousal;

  svm_host_driver #(.NBITS(NBITS), .VSUP_WIDTH(VS), .ASUP_WIDTH(AS), .F_WIDTH(FW),
                    .LOG_SUP_WIDTH(LS)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .cfg_v_intercept(cfg_v_intercept), .cfg_a_intercept(cfg_a_intercept),
    .w_valid(w_valid), .w_ready(w_ready), .w_v_support(w_v_support), .w_a_support(w_a_support),
    .w_v_alpha(w_v_alpha), .w_a_alpha(w_a_alpha), .mem_write_ready(mem_write_ready),
    .intercept_valid(intercept_valid), .v_in_intercept(v_in_intercept), .a_in_intercept(a_in_intercept),
    .mem_we(mem_we), .mem_write_addr(mem_write_addr), .v_in_support(v_in_support),
    .a_in_support(a_in_support), .v_in_alpha(v_in_alpha), .a_in_alpha(a_in_alpha),
    .mem_write_done(mem_write_done), .loaded(loaded), .s_valid(s_valid), .s_ready(s_ready),
    .s_v_features(s_v_features), .s_a_features(s_a_features), .in_features(in_features),
    .fin_valid(fin_valid), .fin_ready(fin_ready), .valence(valence), .arousal(arousal),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .r_valid(r_valid), .r_ready(r_ready),
    .r_valence(r_valence), .r_arousal(r_arousal)
  );

  typedef struct packed {
    logic [7:0]       addr;
    logic [VWD-1:0]   vs;
    logic [AWD-1:0]   as_;
    logic [NBITS-1:0] va;
    logic [NBITS-1:0] aa;
  } row_t;

  row_t           wq[$];
  logic [FWD-1:0] fq[$];
  logic [1:0]     rq[$];

  int checks = 0, errors = 0, cyc = 0;
  int wr_cnt = 0, first_wr_cyc = 0, icpt_cnt = 0, done_cnt = 0, done_cyc = 0;
  int fin_hs = 0, last_fin_cyc = 0, res_cnt = 0, svm_delay = 0;
  bit b2b_mode = 0, force_en = 0, rr_rand = 0;
  logic [1:0] force_lab = 2'b00;
  logic [IW-1:0] exp_vi = '0, exp_ai = '0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2047:0] rnd_bits();
    logic [2047:0] r;
    for (int i = 0; i < 64; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial forever begin @(posedge clk); cyc++; end

  // Monitor: pops expectations whenever the DUT presents a write, a feature handshake or a result.
  initial begin : mon
    row_t er;
    logic [FWD-1:0] ef, pf_d;
    logic [1:0] eres, pr_d;
    bit pf_v, pr_v;
    pf_v = 0; pr_v = 0; pf_d = '0; pr_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pf_v = 0; pr_v = 0;
      end else begin
        if (!mem_we) begin
          wr_cnt++;
          if (wr_cnt == 1) first_wr_cyc = cyc;
          if (wq.size() == 0) chk(0, "write_unexpected", 64'(mem_write_addr), 64'd0);
          else begin
            er = wq.pop_front();
            chk(mem_write_addr == er.addr && v_in_support == er.vs && a_in_support == er.as_ &&
                v_in_alpha == er.va && a_in_alpha == er.aa, "write_row", 64'(mem_write_addr), 64'(er.addr));
          end
        end
        if (intercept_valid) begin
          icpt_cnt++;
          chk(v_in_intercept == exp_vi && a_in_intercept == exp_ai, "intercept", 64'(v_in_intercept), 64'(exp_vi));
          chk(loaded == 1'b0, "loaded_clear_at_icpt", 64'(loaded), 64'd0);
        end
        if (mem_write_done) begin done_cnt++; done_cyc = cyc; end
        if (pf_v) chk(fin_valid && in_features == pf_d, "fin_stable", in_features[63:0], pf_d[63:0]);
        if (fin_valid && fin_ready) begin
          fin_hs++;
          if (fq.size() == 0) chk(0, "feature_unexpected", in_features[63:0], 64'd0);
          else begin
            ef = fq.pop_front();
            chk(in_features == ef, "feature", in_features[63:0], ef[63:0]);
          end
          if (b2b_mode && (fin_hs % 2 == 0))
            chk(cyc - last_fin_cyc == 1, "feature_b2b", 64'(cyc - last_fin_cyc), 64'd1);
          last_fin_cyc = cyc;
        end
        pf_v = fin_valid && !fin_ready; pf_d = in_features;
        if (pr_v) chk(r_valid && {r_valence, r_arousal} == pr_d, "result_stable", 64'({r_valence, r_arousal}), 64'(pr_d));
        if (dout_valid && r_valid) chk(dout_ready == 1'b0, "dout_stall", 64'(dout_ready), 64'd0);
        if (r_valid && r_ready) begin
          res_cnt++;
          if (rq.size() == 0) chk(0, "result_unexpected", 64'({r_valence, r_arousal}), 64'd0);
          else begin
            eres = rq.pop_front();
            chk({r_valence, r_arousal} == eres, "result", 64'({r_valence, r_arousal}), 64'(eres));
          end
        end
        pr_v = r_valid && !r_ready; pr_d = {r_valence, r_arousal};
      end
    end
  end

  // SVM model: after each valence+arousal pair, wait svm_delay cycles then return labels.
  initial begin : svm
    int nvec, dly;
    bit vhs, dhs, busy;
    nvec = 0; dly = 0; busy = 0;
    fin_ready = 0; dout_valid = 0; valence = 0; arousal = 0;
    forever begin
      @(negedge clk);
      vhs = fin_valid && fin_ready;
      dhs = dout_valid && dout_ready;
      @(posedge clk); #1;
      if (vhs) nvec++;
      if (dhs) dout_valid = 1'b0;
      if (nvec >= 2 && !busy) begin busy = 1; nvec -= 2; dly = svm_delay; end
      if (busy && !dout_valid) begin
        if (dly == 0) begin
          valence = force_en ? force_lab[1] : 1'($urandom);
          arousal = force_en ? force_lab[0] : 1'($urandom);
          dout_valid = 1'b1;
          rq.push_back({valence, arousal});
          busy = 0;
        end else dly--;
      end
      fin_ready = b2b_mode ? 1'b1 : 1'($urandom_range(1, 0));
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rr_rand) r_ready = 1'($urandom_range(1, 0));
  end

  task automatic do_load(input int stall, input bit toggle, input int abort_at);
    logic [2047:0] t;
    row_t r;
    int sent, to, ic0, dc0;
    sent = 0; to = 0; ic0 = icpt_cnt; dc0 = done_cnt; wr_cnt = 0;
    exp_vi = IW'($urandom); exp_ai = IW'($urandom);
    cfg_v_intercept = exp_vi; cfg_a_intercept = exp_ai;
    mem_write_ready = (stall == 0);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    cfg_v_intercept = ~exp_vi; cfg_a_intercept = ~exp_ai;
    for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
    if (stall > 0) chk(icpt_cnt == ic0, "icpt_held_by_write_ready", 64'(icpt_cnt - ic0), 64'd0);
    mem_write_ready = 1'b1;
    while (sent < FW && to < 3000) begin
      if (abort_at >= 0 && sent == abort_at) break;
      w_valid = toggle ? (to % 2 == 0) : 1'b1;
      t = rnd_bits(); r.vs = t[VWD-1:0];
      t = rnd_bits(); r.as_ = t[AWD-1:0];
      r.va = NBITS'($urandom); r.aa = NBITS'($urandom); r.addr = 8'(sent);
      w_v_support = r.vs; w_a_support = r.as_; w_v_alpha = r.va; w_a_alpha = r.aa;
      load_start = (to == 60);
      if (w_valid && w_ready) begin wq.push_back(r); sent++; end
      @(posedge clk); #1;
      to++;
    end
    w_valid = 1'b0; load_start = 1'b0;
    if (abort_at >= 0) begin
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk(mem_we == 1'b1, "abort_mem_we", 64'(mem_we), 64'd1);
      chk(loaded == 1'b0, "abort_loaded", 64'(loaded), 64'd0);
      chk(w_ready == 1'b0 && s_ready == 1'b0, "abort_idle_readies", 64'({w_ready, s_ready}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      wq.delete();
    end else begin
      chk(sent == FW, "rows_sent", 64'(sent), 64'(FW));
      to = 0;
      while (done_cnt == dc0 && to < 50) begin @(posedge clk); #1; to++; end
      repeat (3) @(posedge clk);
      #1;
      chk(done_cnt - dc0 == 1, "write_done_pulses", 64'(done_cnt - dc0), 64'd1);
      chk(icpt_cnt - ic0 == 1, "intercept_pulses", 64'(icpt_cnt - ic0), 64'd1);
      chk(wr_cnt == FW, "write_count", 64'(wr_cnt), 64'(FW));
      chk(wq.size() == 0, "write_queue_empty", 64'(wq.size()), 64'd0);
      chk(loaded == 1'b1, "loaded_after_load", 64'(loaded), 64'd1);
      if (!toggle) chk(done_cyc - first_wr_cyc == FW + 1, "write_burst_gap", 64'(done_cyc - first_wr_cyc), 64'(FW + 1));
    end
  endtask

  task automatic send_sample();
    logic [2047:0] t;
    logic [FWD-1:0] v, a;
    int to;
    to = 0;
    t = rnd_bits(); v = t[FWD-1:0];
    t = rnd_bits(); a = t[FWD-1:0];
    s_v_features = v; s_a_features = a; s_valid = 1'b1;
    while (!s_ready && to < 2000) begin @(posedge clk); #1; to++; end
    if (!s_ready) chk(0, "sample_accept_timeout", 64'd0, 64'd1);
    else begin
      fq.push_back(v); fq.push_back(a);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    t = rnd_bits(); s_v_features = t[FWD-1:0];
  endtask

  task automatic wait_results(input int target, input int limit);
    int to;
    to = 0;
    while (res_cnt < target && to < limit) begin @(posedge clk); #1; to++; end
    chk(res_cnt >= target, "result_count", 64'(res_cnt), 64'(target));
  endtask

  initial begin : stim
    int n0, to;
    rst = 1'b1; load_start = 0; cfg_v_intercept = '0; cfg_a_intercept = '0;
    w_valid = 0; w_v_support = '0; w_a_support = '0; w_v_alpha = '0; w_a_alpha = '0;
    mem_write_ready = 0; s_valid = 0; s_v_features = '0; s_a_features = '0; r_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(mem_we == 1'b1, "reset_mem_we", 64'(mem_we), 64'd1);
    chk({intercept_valid, mem_write_done, loaded} == 3'b000, "reset_strobes", 64'({intercept_valid, mem_write_done, loaded}), 64'd0);
    chk({w_ready, s_ready, fin_valid, dout_ready, r_valid} == 5'b0, "reset_handshakes",
        64'({w_ready, s_ready, fin_valid, dout_ready, r_valid}), 64'd0);
    chk(mem_write_addr == 8'd0 && in_features == '0, "reset_data", 64'(mem_write_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_load(0, 1'b0, -1);

    // Directed sample: back-to-back feature acceptance, labels 1/0 after 50 cycles.
    b2b_mode = 1; force_en = 1; force_lab = 2'b10; svm_delay = 50; r_ready = 1;
    n0 = res_cnt;
    send_sample();
    wait_results(n0 + 1, 500);
    b2b_mode = 0; force_en = 0;

    // Result buffer full: second result must stall until r_ready pulses.
    r_ready = 0; svm_delay = 5; n0 = res_cnt;
    send_sample();
    to = 0;
    while (!r_valid && to < 1000) begin @(posedge clk); #1; to++; end
    chk(r_valid == 1'b1, "first_result_valid", 64'(r_valid), 64'd1);
    send_sample();
    to = 0;
    while (!dout_valid && to < 1000) begin @(posedge clk); #1; to++; end
    repeat (5) @(posedge clk);
    #1;
    chk(r_valid == 1'b1 && dout_ready == 1'b0, "held_result_blocks_dout", 64'({r_valid, dout_ready}), 64'b10);
    chk(res_cnt == n0, "no_result_without_ready", 64'(res_cnt), 64'(n0));
    r_ready = 1; @(posedge clk); #1; r_ready = 0;
    chk(res_cnt == n0 + 1, "first_result_popped", 64'(res_cnt), 64'(n0 + 1));
    to = 0;
    while (!r_valid && to < 1000) begin @(posedge clk); #1; to++; end
    chk(r_valid == 1'b1, "second_result_valid", 64'(r_valid), 64'd1);
    r_ready = 1; @(posedge clk); #1; r_ready = 0;
    chk(res_cnt == n0 + 2, "second_result_popped", 64'(res_cnt), 64'(n0 + 2));

    // Reload from RUN with write-ready stalled and w_valid toggling.
    do_load(10, 1'b1, -1);

    // Abort at row 100, then a clean full reload from IDLE.
    do_load(0, 1'b0, 100);
    do_load(0, 1'b0, -1);

    // Randomized samples, random fin_ready / r_ready / SVM latency.
    rr_rand = 1; n0 = res_cnt;
    for (int i = 0; i < 8; i++) begin
      svm_delay = $urandom_range(0, 20);
      send_sample();
    end
    wait_results(n0 + 8, 5000);
    rr_rand = 0; r_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk(fq.size() == 0 && rq.size() == 0 && wq.size() == 0, "queues_drained",
        64'(fq.size() + rq.size() + wq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
